// File: rtl/remote_ctrl_pkg.sv
// remote_ctrl_pkg
// Shared definitions for the IR remote motor driver: command codes from the
// IR decoder, H-bridge motor patterns, the FSM state type, and a helper that
// spots a direction reversal on a single motor.
//
// Motor pattern layout: [3:2] = left motor {IN1, IN2}, [1:0] = right motor
// {IN3, IN4}. Per motor: 10 = forward, 01 = reverse, 00 = coast.
package remote_ctrl_pkg;

    localparam logic [2:0] CMD_STOP  = 3'd0;
    localparam logic [2:0] CMD_FWD   = 3'd1;
    localparam logic [2:0] CMD_BACK  = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_RIGHT = 3'd4;

    localparam logic [3:0] MOT_STOP  = 4'b0000;
    localparam logic [3:0] MOT_FWD   = 4'b1010;
    localparam logic [3:0] MOT_BACK  = 4'b0101;
    localparam logic [3:0] MOT_LEFT  = 4'b0010;
    localparam logic [3:0] MOT_RIGHT = 4'b1000;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_t;

    // True when one motor would switch straight between forward and reverse,
    // which would short the H-bridge through both legs if done in one step.
    function automatic logic pair_reverses(input logic [1:0] cur,
                                           input logic [1:0] nxt);
        return ((cur == 2'b10) && (nxt == 2'b01)) ||
               ((cur == 2'b01) && (nxt == 2'b10));
    endfunction

endpackage

// File: rtl/remote_ctrl_decode.sv
// remote_ctrl_decode
// Purely combinational map from a registered IR command code to the desired
// H-bridge pattern. Codes 5-7 are invalid and fall back to stop.
//
// Ports:
//   cmd    - 3-bit command code (0 stop, 1 fwd, 2 back, 3 left, 4 right)
//   target - 4-bit desired motor pattern
module remote_ctrl_decode
    import remote_ctrl_pkg::*;
(
    input  logic [2:0] cmd,
    output logic [3:0] target
);

    always_comb begin
        target = MOT_STOP;
        case (cmd)
            CMD_STOP:  target = MOT_STOP;
            CMD_FWD:   target = MOT_FWD;
            CMD_BACK:  target = MOT_BACK;
            CMD_LEFT:  target = MOT_LEFT;
            CMD_RIGHT: target = MOT_RIGHT;
            default:   target = MOT_STOP;
        endcase
    end

endmodule

// File: rtl/remote_ctrl.sv
// remote_ctrl
// Command-to-motor driver for the smart car IR remote path. Registers the IR
// command, decodes it to an H-bridge pattern, and applies it to the motors.
// Whenever either motor would flip directly between forward and reverse, both
// motors are held in coast for DEAD_CYCLES cycles first.
//
// Parameters:
//   DEAD_CYCLES - coast cycles inserted before a reversal (1..255)
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   data  - 3-bit command code from the IR decoder
//   motor - registered H-bridge lines {left IN1, IN2, right IN3, IN4}
module remote_ctrl
    import remote_ctrl_pkg::*;
#(
    parameter int DEAD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] data,
    output logic [3:0] motor
);

    localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    logic [2:0] cmd_q;
    logic [3:0] target;
    logic       reversal;
    state_t     state;
    logic [7:0] count;

    // Input register: the command code is resampled every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= CMD_STOP;
        end else begin
            cmd_q <= data;
        end
    end

    remote_ctrl_decode u_decode (
        .cmd    (cmd_q),
        .target (target)
    );

    assign reversal = pair_reverses(motor[3:2], target[3:2]) ||
                      pair_reverses(motor[1:0], target[1:0]);

    // Motor FSM. In RUN the target is applied directly unless it reverses a
    // motor; then both motors coast for DEAD_CYCLES cycles. The dead time is
    // fixed once started: later commands only choose what is applied at its end.
    // Leaving DEAD from an all-coast pattern can never itself be a reversal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            motor <= MOT_STOP;
            count <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (reversal) begin
                        motor <= MOT_STOP;
                        count <= DEAD_LOAD;
                        state <= DEAD;
                    end else begin
                        motor <= target;
                    end
                end
                DEAD: begin
                    if (count == 8'd0) begin
                        motor <= target;
                        state <= RUN;
                    end else begin
                        motor <= MOT_STOP;
                        count <= count - 8'd1;
                    end
                end
                default: begin
                    motor <= MOT_STOP;
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_ctrl.sv
// tb_remote_ctrl
// Self-checking bench for remote_ctrl: a table of directed steps, hand-written
// dead-time corner cases (command change and reset during coast), and a
// randomized command sequence checked cycle by cycle against a reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_remote_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] data;
    logic [3:0] motor;

    int checks_total;
    int checks_passed;

    remote_ctrl #(.DEAD_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .motor (motor)
    );

    // 50 MHz clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [2:0] data;
        int         cycles;
        logic [3:0] expected;
    } vec_t;

    vec_t vecs[$];

    // Expected pattern for each command code, straight from the command table.
    function automatic logic [3:0] ref_pattern(input int code);
        case (code)
            1:       return 4'b1010;
            2:       return 4'b0101;
            3:       return 4'b0010;
            4:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // A motor reverses when it goes from one driven direction to the other.
    function automatic logic ref_reverses(input logic [3:0] a, input logic [3:0] b);
        logic r;
        r = 1'b0;
        for (int m = 0; m < 2; m++) begin
            logic [1:0] pa, pb;
            pa = a[2*m +: 2];
            pb = b[2*m +: 2];
            if (pa != 2'b00 && pb != 2'b00 && pa != pb) r = 1'b1;
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [3:0] actual,
                                input logic [3:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: motor=%b expected=%b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] d, input int cycles);
        data = d;
        repeat (cycles) @(negedge clk);
    endtask

    // Drive one command and check every sample for the given number of cycles
    // against the dead-time rule: old pattern for one sample, then either the
    // target directly or D coast samples followed by the target.
    task automatic run_model_step(input logic [2:0] d, input int cycles,
                                  input logic [3:0] prev, input string name);
        logic [3:0] tgt, exp_m, last;
        logic       rev;
        tgt  = ref_pattern(int'(d));
        rev  = ref_reverses(prev, tgt);
        last = prev;
        data = d;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            if (k == 1)                exp_m = prev;
            else if (rev && k <= 1 + D) exp_m = 4'b0000;
            else                       exp_m = tgt;
            check_output(name, motor, exp_m);
            checks_total++;
            if (ref_reverses(last, motor)) begin
                $display("[TB] FAIL %s_adjacent: motor=%b after %b", name, motor, last);
            end else begin
                checks_passed++;
            end
            last = motor;
        end
    endtask

    initial begin
        logic [3:0] prev;
        logic [2:0] code;
        checks_total  = 0;
        checks_passed = 0;
        data  = 3'd0;
        rst_n = 1'b1;

        // Reset for 21 ns.
        #1 rst_n = 1'b0;
        #4 check_output("reset_async", motor, 4'b0000);
        #17 rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_idle_1", motor, 4'b0000);
        apply_stimulus(3'd0, 2);
        check_output("reset_idle_2", motor, 4'b0000);

        // Directed table: each row drives data, waits, then compares.
        vecs.push_back(vec_t'{3'd1, 2, 4'b1010});
        vecs.push_back(vec_t'{3'd3, 1, 4'b1010});
        vecs.push_back(vec_t'{3'd3, 1, 4'b0010});
        vecs.push_back(vec_t'{3'd1, 2, 4'b1010});
        vecs.push_back(vec_t'{3'd2, 1, 4'b1010});
        vecs.push_back(vec_t'{3'd2, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 1, 4'b0101});
        vecs.push_back(vec_t'{3'd5, 1, 4'b0101});
        vecs.push_back(vec_t'{3'd5, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 2, 4'b0101});
        vecs.push_back(vec_t'{3'd6, 2, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 2, 4'b0101});
        vecs.push_back(vec_t'{3'd7, 2, 4'b0000});
        vecs.push_back(vec_t'{3'd1, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd1, 1, 4'b1010});
        vecs.push_back(vec_t'{3'd4, 2, 4'b1000});
        vecs.push_back(vec_t'{3'd0, 2, 4'b0000});
        vecs.push_back(vec_t'{3'd2, 2, 4'b0101});
        vecs.push_back(vec_t'{3'd1, 1, 4'b0101});
        vecs.push_back(vec_t'{3'd1, 1, 4'b0000});
        vecs.push_back(vec_t'{3'd1, 3, 4'b0000});
        vecs.push_back(vec_t'{3'd1, 1, 4'b1010});
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].data, vecs[i].cycles);
            check_output($sformatf("table_%0d", i), motor, vecs[i].expected);
        end

        // Command change during dead time: coast length unchanged, latest
        // command applied at the end.
        apply_stimulus(3'd2, 1);
        check_output("middead_pre", motor, 4'b1010);
        apply_stimulus(3'd2, 1);
        check_output("middead_coast_1", motor, 4'b0000);
        for (int k = 2; k <= D; k++) begin
            apply_stimulus(3'd4, 1);
            check_output($sformatf("middead_coast_%0d", k), motor, 4'b0000);
        end
        apply_stimulus(3'd4, 1);
        check_output("middead_end", motor, 4'b1000);

        // Reset during dead time.
        apply_stimulus(3'd1, 3);
        check_output("rstdead_fwd", motor, 4'b1010);
        apply_stimulus(3'd2, 3);
        check_output("rstdead_in_dead", motor, 4'b0000);
        #5 rst_n = 1'b0;
        #1 check_output("rstdead_async", motor, 4'b0000);
        #20 rst_n = 1'b1;
        data = 3'd1;
        @(negedge clk);
        check_output("rstdead_release", motor, 4'b0000);
        @(negedge clk);
        check_output("rstdead_follow", motor, 4'b1010);

        // Settle to a known state, then random commands held 200 ns each.
        apply_stimulus(3'd0, 3);
        check_output("rand_pre", motor, 4'b0000);
        prev = 4'b0000;
        for (int n = 0; n < 10; n++) begin
            code = 3'($urandom_range(0, 4));
            run_model_step(code, 10, prev, $sformatf("rand_%0d_cmd%0d", n, code));
            prev = ref_pattern(int'(code));
        end

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
